// File: rtl/ex_lsu_pkg.sv
// ex_lsu_pkg: shared opcode/type encodings and FSM state type for the execute/load-store stage
package ex_lsu_pkg;

    localparam logic [3:0] RTLOP_ADD  = 4'b0000;
    localparam logic [3:0] RTLOP_SLL  = 4'b0001;
    localparam logic [3:0] RTLOP_SLT  = 4'b0010;
    localparam logic [3:0] RTLOP_SLTU = 4'b0011;
    localparam logic [3:0] RTLOP_XOR  = 4'b0100;
    localparam logic [3:0] RTLOP_SHR  = 4'b0101;
    localparam logic [3:0] RTLOP_OR   = 4'b0110;
    localparam logic [3:0] RTLOP_AND  = 4'b0111;
    localparam logic [3:0] RTLOP_SAR  = 4'b1101;

    localparam logic [1:0] RTLTYPE_ARICH = 2'b00;
    localparam logic [1:0] RTLTYPE_RMEM  = 2'b01;
    localparam logic [1:0] RTLTYPE_WMEM  = 2'b10;

    typedef enum logic {
        S_IDLE     = 1'b0,
        S_MEM_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/ex_alu.sv
// ex_alu: combinational integer ALU for the execute stage
module ex_alu
    import ex_lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [3:0]        rtlop_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] result_o
);

    localparam int SW = $clog2(DATA_W);

    logic [SW-1:0] sh;

    assign sh = b_i[SW-1:0];

    // select the result of the requested operation; unknown codes yield zero
    always_comb begin
        result_o = '0;
        case (rtlop_i)
            RTLOP_ADD:  result_o = a_i + b_i;
            RTLOP_SLL:  result_o = a_i << sh;
            RTLOP_SLT:  result_o = DATA_W'($signed(a_i) < $signed(b_i));
            RTLOP_SLTU: result_o = DATA_W'(a_i < b_i);
            RTLOP_XOR:  result_o = a_i ^ b_i;
            RTLOP_SHR:  result_o = a_i >> sh;
            RTLOP_SAR:  result_o = DATA_W'($signed(a_i) >>> sh);
            RTLOP_OR:   result_o = a_i | b_i;
            RTLOP_AND:  result_o = a_i & b_i;
            default:    result_o = '0;
        endcase
    end

endmodule

// File: rtl/ex_lsu.sv
// ex_lsu: execute/load-store stage with ALU writeback, req/ack data memory port and timeout
module ex_lsu
    import ex_lsu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        rtlop_i,
    input  logic [1:0]        rtltype_i,
    input  logic [DATA_W-1:0] pc_i,
    input  logic [DATA_W-1:0] src1_i,
    input  logic [DATA_W-1:0] src2_i,
    input  logic [REG_AW-1:0] gprs_waddr_i,
    output logic              gprs_we,
    output logic [REG_AW-1:0] gprs_waddr,
    output logic [DATA_W-1:0] gprs_wdata,
    output logic [REG_AW-1:0] ex_gprs_waddr,
    output logic [DATA_W-1:0] ex_gprs_wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_o,
    output logic              err_o,
    output logic [DATA_W-1:0] err_pc_o
);

    localparam int CW = $clog2(TIMEOUT);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              in_ready_q, in_ready_d;
    logic              gprs_we_q, gprs_we_d;
    logic [REG_AW-1:0] gprs_waddr_q, gprs_waddr_d;
    logic [DATA_W-1:0] gprs_wdata_q, gprs_wdata_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] err_pc_q, err_pc_d;
    logic [REG_AW-1:0] pend_waddr_q, pend_waddr_d;
    logic [DATA_W-1:0] pend_pc_q, pend_pc_d;
    logic [DATA_W-1:0] alu_res, addr;
    logic              accept, is_mem;

    ex_alu #(.DATA_W(DATA_W)) u_alu (
        .rtlop_i  (rtlop_i),
        .a_i      (src1_i),
        .b_i      (src2_i),
        .result_o (alu_res)
    );

    assign accept = in_valid & in_ready_q;
    assign is_mem = (rtltype_i == RTLTYPE_RMEM) | (rtltype_i == RTLTYPE_WMEM);
    assign addr   = (rtltype_i == RTLTYPE_RMEM) ? src1_i + src2_i : src1_i;

    // next-state: issue new bundles in IDLE, wait for ack or timeout in MEM_WAIT
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        in_ready_d   = in_ready_q;
        gprs_we_d    = 1'b0;
        gprs_waddr_d = gprs_waddr_q;
        gprs_wdata_d = gprs_wdata_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        err_d        = 1'b0;
        err_pc_d     = err_pc_q;
        pend_waddr_d = pend_waddr_q;
        pend_pc_d    = pend_pc_q;
        if (state_q == S_IDLE) begin
            in_ready_d = 1'b1;
            if (accept && rtltype_i == RTLTYPE_ARICH) begin
                gprs_we_d    = |gprs_waddr_i;
                gprs_waddr_d = |gprs_waddr_i ? gprs_waddr_i : gprs_waddr_q;
                gprs_wdata_d = |gprs_waddr_i ? alu_res : gprs_wdata_q;
            end else if (accept && is_mem && !(|addr[1:0])) begin
                state_d      = S_MEM_WAIT;
                cnt_d        = '0;
                in_ready_d   = 1'b0;
                mem_req_d    = 1'b1;
                mem_we_d     = rtltype_i == RTLTYPE_WMEM;
                mem_addr_d   = addr;
                mem_wdata_d  = src2_i;
                pend_waddr_d = gprs_waddr_i;
                pend_pc_d    = pc_i;
            end else if (accept) begin
                err_d    = 1'b1;
                err_pc_d = pc_i;
            end
        end else begin
            if (mem_ack || cnt_q == CW'(TIMEOUT - 1)) begin
                state_d    = S_IDLE;
                in_ready_d = 1'b1;
                mem_req_d  = 1'b0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
            if (mem_ack && !mem_we_q && |pend_waddr_q) begin
                gprs_we_d    = 1'b1;
                gprs_waddr_d = pend_waddr_q;
                gprs_wdata_d = mem_rdata;
            end
            if (!mem_ack && cnt_q == CW'(TIMEOUT - 1)) begin
                err_d    = 1'b1;
                err_pc_d = pend_pc_q;
            end
        end
    end

    // state and output registers, all cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            in_ready_q   <= 1'b0;
            gprs_we_q    <= 1'b0;
            gprs_waddr_q <= '0;
            gprs_wdata_q <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            err_q        <= 1'b0;
            err_pc_q     <= '0;
            pend_waddr_q <= '0;
            pend_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            in_ready_q   <= in_ready_d;
            gprs_we_q    <= gprs_we_d;
            gprs_waddr_q <= gprs_waddr_d;
            gprs_wdata_q <= gprs_wdata_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            err_q        <= err_d;
            err_pc_q     <= err_pc_d;
            pend_waddr_q <= pend_waddr_d;
            pend_pc_q    <= pend_pc_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign stall_o       = ~in_ready_q;
    assign gprs_we       = gprs_we_q;
    assign gprs_waddr    = gprs_waddr_q;
    assign gprs_wdata    = gprs_wdata_q;
    assign ex_gprs_waddr = gprs_we_q ? gprs_waddr_q : '0;
    assign ex_gprs_wdata = gprs_wdata_q;
    assign mem_req       = mem_req_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign err_o         = err_q;
    assign err_pc_o      = err_pc_q;

endmodule

// File: tb/tb_ex_lsu.sv
// tb_ex_lsu: directed scoreboard bench for ex_lsu
module tb_ex_lsu;
    import ex_lsu_pkg::*;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } wb_t;

    typedef struct {
        logic        we;
        logic [31:0] a;
        logic [31:0] d;
    } mem_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  rtlop_i = '0;
    logic [1:0]  rtltype_i = '0;
    logic [31:0] pc_i = '0, src1_i = '0, src2_i = '0;
    logic [4:0]  gprs_waddr_i = '0;
    logic        gprs_we;
    logic [4:0]  gprs_waddr, ex_gprs_waddr;
    logic [31:0] gprs_wdata, ex_gprs_wdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        stall_o, err_o;
    logic [31:0] err_pc_o;

    int tests = 0;
    int failed = 0;
    int req_cycles = 0;
    wb_t  wb_q[$];
    mem_t mem_q[$];
    logic [31:0] err_q[$];

    always #5 clk = ~clk;

    ex_lsu #(.DATA_W(32), .REG_AW(5), .TIMEOUT(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .rtlop_i       (rtlop_i),
        .rtltype_i     (rtltype_i),
        .pc_i          (pc_i),
        .src1_i        (src1_i),
        .src2_i        (src2_i),
        .gprs_waddr_i  (gprs_waddr_i),
        .gprs_we       (gprs_we),
        .gprs_waddr    (gprs_waddr),
        .gprs_wdata    (gprs_wdata),
        .ex_gprs_waddr (ex_gprs_waddr),
        .ex_gprs_wdata (ex_gprs_wdata),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .stall_o       (stall_o),
        .err_o         (err_o),
        .err_pc_o      (err_pc_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bad(input string name);
        tests++;
        failed++;
        $display("FAIL %s: unexpected event, got 1 expected 0", name);
    endtask

    // monitor: compares every presented writeback, error and memory request to the scoreboard
    always @(negedge clk) begin
        if (mem_req) begin
            req_cycles++;
            if (mem_q.size() == 0) bad("mem_req_unexpected");
            else begin
                chk("mem_we", 32'(mem_we), 32'(mem_q[0].we));
                chk("mem_addr", mem_addr, mem_q[0].a);
                if (mem_q[0].we) chk("mem_wdata", mem_wdata, mem_q[0].d);
            end
        end
        if (gprs_we) begin
            if (wb_q.size() == 0) bad("gprs_we_unexpected");
            else begin
                chk("gprs_waddr", 32'(gprs_waddr), 32'(wb_q[0].a));
                chk("gprs_wdata", gprs_wdata, wb_q[0].d);
                chk("ex_gprs_waddr", 32'(ex_gprs_waddr), 32'(wb_q[0].a));
                chk("ex_gprs_wdata", ex_gprs_wdata, wb_q[0].d);
                wb_q.delete(0);
            end
        end
        if (err_o) begin
            if (err_q.size() == 0) bad("err_unexpected");
            else begin
                chk("err_pc", err_pc_o, err_q[0]);
                err_q.delete(0);
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [1:0] ty, input logic [31:0] pc,
                         input logic [31:0] s1, input logic [31:0] s2, input logic [4:0] wa);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            bad("in_ready_timeout");
            return;
        end
        in_valid = 1'b1;
        rtlop_i = op;
        rtltype_i = ty;
        pc_i = pc;
        src1_i = s1;
        src2_i = s2;
        gprs_waddr_i = wa;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic arith(input string name, input logic [3:0] op, input logic [31:0] s1,
                         input logic [31:0] s2, input logic [4:0] wa, input logic [31:0] exp);
        if (wa != 5'd0) wb_q.push_back('{a: wa, d: exp});
        issue(op, RTLTYPE_ARICH, 32'h10, s1, s2, wa);
        chk({name, "_we"}, 32'(gprs_we), 32'(wa != 5'd0));
        chk({name, "_fwd_addr"}, 32'(ex_gprs_waddr), 32'(wa));
    endtask

    task automatic memop(input string name, input logic [1:0] ty, input logic [31:0] pc,
                         input logic [31:0] s1, input logic [31:0] s2, input logic [4:0] wa,
                         input int ack_after, input logic [31:0] rdata, input logic [31:0] exp_addr);
        mem_q.push_back('{we: ty == RTLTYPE_WMEM, a: exp_addr, d: s2});
        if (ty == RTLTYPE_RMEM && ack_after > 0 && wa != 5'd0) wb_q.push_back('{a: wa, d: rdata});
        if (ack_after == 0) err_q.push_back(pc);
        req_cycles = 0;
        issue(4'd0, ty, pc, s1, s2, wa);
        chk({name, "_stall"}, 32'(stall_o), 32'd1);
        chk({name, "_req_start"}, 32'(mem_req), 32'd1);
        if (ack_after > 0) begin
            repeat (ack_after - 1) begin
                @(posedge clk); #1;
            end
            mem_ack = 1'b1;
            mem_rdata = rdata;
            @(posedge clk); #1;
            mem_ack = 1'b0;
        end else begin
            int n = 0;
            while (mem_req && n < 64) begin
                @(posedge clk); #1;
                n++;
            end
        end
        chk({name, "_req_done"}, 32'(mem_req), 32'd0);
        chk({name, "_ready_back"}, 32'(in_ready), 32'd1);
        chk({name, "_req_cycles"}, 32'(req_cycles), ack_after > 0 ? 32'(ack_after) : 32'd16);
        if (mem_q.size() > 0) mem_q.delete(0);
    endtask

    task automatic errop(input string name, input logic [1:0] ty, input logic [31:0] pc,
                         input logic [31:0] s1, input logic [31:0] s2);
        err_q.push_back(pc);
        issue(4'd0, ty, pc, s1, s2, 5'd6);
        chk({name, "_no_req"}, 32'(mem_req), 32'd0);
        chk({name, "_err"}, 32'(err_o), 32'd1);
        chk({name, "_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_gprs_we", 32'(gprs_we), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_rst", 32'(in_ready), 32'd1);

        arith("add", RTLOP_ADD, 32'd5, 32'hFFFFFFFD, 5'd3, 32'd2);
        arith("add_x0", RTLOP_ADD, 32'd5, 32'hFFFFFFFD, 5'd0, 32'd0);
        arith("sar", RTLOP_SAR, 32'h80000000, 32'd4, 5'd4, 32'hF8000000);
        arith("shr", RTLOP_SHR, 32'h80000000, 32'd4, 5'd5, 32'h08000000);
        arith("slt", RTLOP_SLT, 32'hFFFFFFFF, 32'd1, 5'd6, 32'd1);
        arith("sltu", RTLOP_SLTU, 32'hFFFFFFFF, 32'd1, 5'd7, 32'd0);
        arith("sll", RTLOP_SLL, 32'h00000003, 32'h00000024, 5'd8, 32'h00000030);
        arith("xor", RTLOP_XOR, 32'hF0F0F0F0, 32'hFF00FF00, 5'd9, 32'h0FF00FF0);
        arith("or", RTLOP_OR, 32'hF0F0F0F0, 32'h0F000000, 5'd10, 32'hFFF0F0F0);
        arith("and", RTLOP_AND, 32'hF0F0F0F0, 32'hFF00FF00, 5'd11, 32'hF000F000);
        @(posedge clk); #1;
        chk("we_pulse", 32'(gprs_we), 32'd0);
        chk("waddr_hold", 32'(gprs_waddr), 32'd11);
        chk("fwd_x0_idle", 32'(ex_gprs_waddr), 32'd0);

        memop("load", RTLTYPE_RMEM, 32'h20, 32'h100, 32'd4, 5'd7, 3, 32'hDEADBEEF, 32'h104);
        memop("store", RTLTYPE_WMEM, 32'h24, 32'h200, 32'h12345678, 5'd2, 1, 32'h0, 32'h200);
        memop("timeout", RTLTYPE_RMEM, 32'h44, 32'h300, 32'd0, 5'd5, 0, 32'h0, 32'h300);
        memop("ack_last", RTLTYPE_RMEM, 32'h48, 32'h380, 32'd0, 5'd8, 16, 32'hCAFEF00D, 32'h380);

        errop("misalign_w", RTLTYPE_WMEM, 32'h50, 32'h102, 32'h1);
        errop("misalign_r", RTLTYPE_RMEM, 32'h54, 32'h101, 32'h1);
        errop("bad_type", 2'b11, 32'h58, 32'h0, 32'h0);

        mem_ack = 1'b1;
        mem_rdata = 32'h55AA55AA;
        repeat (2) @(posedge clk);
        #1;
        mem_ack = 1'b0;
        chk("idle_ack_no_req", 32'(mem_req), 32'd0);
        chk("idle_ack_no_we", 32'(gprs_we), 32'd0);

        mem_q.push_back('{we: 1'b0, a: 32'h400, d: 32'h0});
        issue(4'd0, RTLTYPE_RMEM, 32'h60, 32'h400, 32'h0, 5'd9);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rstmid_req", 32'(mem_req), 32'd0);
        chk("rstmid_ready", 32'(in_ready), 32'd0);
        chk("rstmid_we", 32'(gprs_we), 32'd0);
        chk("rstmid_addr", mem_addr, 32'd0);
        chk("rstmid_waddr", 32'(gprs_waddr), 32'd0);
        if (mem_q.size() > 0) mem_q.delete(0);
        rst = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 32'h11111111;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        chk("late_ack_we", 32'(gprs_we), 32'd0);
        chk("late_ack_req", 32'(mem_req), 32'd0);

        repeat (3) @(posedge clk);
        #1;
        chk("wb_q_empty", 32'(wb_q.size()), 32'd0);
        chk("err_q_empty", 32'(err_q.size()), 32'd0);
        chk("mem_q_empty", 32'(mem_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
